// File: rtl/gem_pkg.sv
`default_nettype none
// ============================================================================
// Package : gem_pkg
// Shared GEM constants, cluster field layout and FEB-to-pad-address mapping.
// Revision: 1.0
// ============================================================================
package gem_pkg;

    localparam int MXFEB      = 24;
    localparam int MXCLUSTERS = 8;
    localparam int MXPADS     = 64;
    localparam int MXADRB     = 11;
    localparam int MXCNTB     = 3;
    localparam int MXCLSTB    = 14;
    localparam int MXWPTRB    = 4;

    localparam logic [MXCLSTB-1:0] BLANK_CLUSTER = 14'h07FF;

    // Field order matches the co-pad finder: cnt in the top bits, start pad below.
    typedef struct packed {
        logic [MXCNTB-1:0] cnt;
        logic [MXADRB-1:0] adr;
    } gem_cluster_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_FLUSH = 2'd2
    } pack_state_t;

    // FEBs tile the chamber as 8 rows of 3 columns, 64 pads per FEB.
    function automatic logic [MXADRB-1:0] feb_base(input logic [4:0] feb_id);
        logic [MXADRB-1:0] row;
        logic [MXADRB-1:0] col;
        row = MXADRB'(feb_id[2:0]);
        col = MXADRB'(feb_id[4:3]);
        return row * MXADRB'(192) + col * MXADRB'(64);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gem_cluster_packer_if.sv
`default_nettype none
// ============================================================================
// Interface : gem_cluster_packer_if
// FEB hit-word handshake and frame-close strobe into the cluster packer.
// Revision: 1.0
// ============================================================================
interface gem_cluster_packer_if;

    logic        feb_valid;
    logic        feb_ready;
    logic [4:0]  feb_id;
    logic [63:0] feb_hits;
    logic        frame_end;

    modport master (
        output feb_valid,
        output feb_id,
        output feb_hits,
        output frame_end,
        input  feb_ready
    );

    modport slave (
        input  feb_valid,
        input  feb_id,
        input  feb_hits,
        input  frame_end,
        output feb_ready
    );

endinterface
`default_nettype wire

// File: rtl/gem_run_tracker.sv
`default_nettype none
// ============================================================================
// Module : gem_run_tracker
// Per-pad run-length tracker; GEM_CLUSTER_SPLIT_EN splits runs longer than 8 pads.
// Revision: 1.0
// ============================================================================
module gem_run_tracker
    import gem_pkg::*;
(
    input  wire                clk,
    input  wire                rst,
    input  wire                i_en,
    input  wire                i_hit,
    input  wire                i_last,
    input  wire [MXADRB-1:0]   i_adr,
    output logic               o_split_vld,
    output gem_cluster_t       o_split_cluster,
    output logic               o_close_vld,
    output gem_cluster_t       o_close_cluster
);

    logic              r_open;
    logic [MXADRB-1:0] r_start;
    logic [MXCNTB-1:0] r_len;

    logic              w_open_nxt;
    logic [MXADRB-1:0] w_start_nxt;
    logic [MXCNTB-1:0] w_len_nxt;

    always_comb begin
        w_open_nxt          = r_open;
        w_start_nxt         = r_start;
        w_len_nxt           = r_len;
        o_split_vld         = 1'b0;
        o_split_cluster.cnt = r_len;
        o_split_cluster.adr = r_start;
        o_close_vld         = 1'b0;
        o_close_cluster.cnt = r_len;
        o_close_cluster.adr = r_start;
        if (i_en) begin
            if (i_hit) begin
                if (!r_open) begin
                    w_open_nxt  = 1'b1;
                    w_start_nxt = i_adr;
                    w_len_nxt   = '0;
                end else if (r_len != '1) begin
                    w_len_nxt = r_len + 3'd1;
                end
`ifdef GEM_CLUSTER_SPLIT_EN
                else begin
                    o_split_vld = 1'b1;
                    w_start_nxt = i_adr;
                    w_len_nxt   = '0;
                end
`endif
            end else if (r_open) begin
                o_close_vld = 1'b1;
                w_open_nxt  = 1'b0;
            end
            // The last pad closes whatever run survives it, including this pad.
            if (i_last && w_open_nxt) begin
                o_close_vld         = 1'b1;
                o_close_cluster.cnt = w_len_nxt;
                o_close_cluster.adr = w_start_nxt;
                w_open_nxt          = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_open  <= 1'b0;
            r_start <= '0;
            r_len   <= '0;
        end else begin
            r_open  <= w_open_nxt;
            r_start <= w_start_nxt;
            r_len   <= w_len_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/gem_cluster_packer.sv
`default_nettype none
// ============================================================================
// Module : gem_cluster_packer
// Scans FEB hit words into up to 8 GEM clusters per frame (GEM_CLUSTER_SPLIT_EN in tracker).
// Revision: 1.0
// ============================================================================
module gem_cluster_packer
    import gem_pkg::*;
(
    input  wire                  clock,
    input  wire                  reset,
    gem_cluster_packer_if.slave  feb,
    output logic [MXCLSTB-1:0]   cluster0,
    output logic [MXCLSTB-1:0]   cluster1,
    output logic [MXCLSTB-1:0]   cluster2,
    output logic [MXCLSTB-1:0]   cluster3,
    output logic [MXCLSTB-1:0]   cluster4,
    output logic [MXCLSTB-1:0]   cluster5,
    output logic [MXCLSTB-1:0]   cluster6,
    output logic [MXCLSTB-1:0]   cluster7,
    output logic                 clusters_valid,
    output logic [3:0]           n_clusters,
    output logic                 overflow
);

    localparam logic [MXWPTRB-1:0] WPTR_FULL = MXWPTRB'(MXCLUSTERS);

    pack_state_t          r_state;
    pack_state_t          w_state_nxt;

    logic [MXPADS-1:0]    r_hits;
    logic [MXADRB-1:0]    r_base;
    logic [5:0]           r_pad;
    logic                 r_pend;

    logic [MXCLSTB-1:0]   r_buf [MXCLUSTERS];
    logic [MXWPTRB-1:0]   r_wptr;
    logic                 r_ovf_int;

    logic [MXCLSTB-1:0]   r_out [MXCLUSTERS];
    logic                 r_valid;
    logic [3:0]           r_n;
    logic                 r_ovf;

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_scan;
    logic                 w_last;

    logic                 w_split_vld;
    gem_cluster_t         w_split_cluster;
    logic                 w_close_vld;
    gem_cluster_t         w_close_cluster;

    logic                 w_wr_a;
    logic                 w_wr_b;
    logic [MXWPTRB-1:0]   w_ptr_b;
    logic [MXWPTRB-1:0]   w_wptr_nxt;
    logic                 w_drop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_accept    = 1'b0;
        w_scan      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (feb.feb_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SCAN;
                end else if (feb.frame_end) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_SCAN: begin
                w_scan = 1'b1;
                if (r_pad == 6'(MXPADS - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = (r_pend || feb.frame_end) ? ST_FLUSH : ST_IDLE;
                end
            end
            ST_FLUSH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign feb.feb_ready = w_ready;

    gem_run_tracker u_run_tracker (
        .clk             (clock),
        .rst             (reset),
        .i_en            (w_scan),
        .i_hit           (r_hits[r_pad]),
        .i_last          (w_last),
        .i_adr           (r_base + MXADRB'(r_pad)),
        .o_split_vld     (w_split_vld),
        .o_split_cluster (w_split_cluster),
        .o_close_vld     (w_close_vld),
        .o_close_cluster (w_close_cluster)
    );

    // A split and a final close can both land in one cycle; the split is older.
    always_comb begin
        w_wr_a     = w_split_vld && (r_wptr < WPTR_FULL);
        w_ptr_b    = w_wr_a ? (r_wptr + 4'd1) : r_wptr;
        w_wr_b     = w_close_vld && (w_ptr_b < WPTR_FULL);
        w_wptr_nxt = w_wr_b ? (w_ptr_b + 4'd1) : w_ptr_b;
        w_drop     = (w_split_vld && !w_wr_a) || (w_close_vld && !w_wr_b);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hits    <= '0;
            r_base    <= '0;
            r_pad     <= '0;
            r_pend    <= 1'b0;
            r_wptr    <= '0;
            r_ovf_int <= 1'b0;
            r_valid   <= 1'b0;
            r_n       <= '0;
            r_ovf     <= 1'b0;
            for (int i = 0; i < MXCLUSTERS; i++) begin
                r_buf[i] <= BLANK_CLUSTER;
                r_out[i] <= BLANK_CLUSTER;
            end
        end else begin
            r_valid <= 1'b0;
            if (w_accept) begin
                r_hits <= (feb.feb_id < 5'(MXFEB)) ? feb.feb_hits : '0;
                r_base <= feb_base(feb.feb_id);
                r_pad  <= '0;
                r_pend <= feb.frame_end;
            end
            if (w_scan) begin
                r_pad <= r_pad + 6'd1;
                if (feb.frame_end) begin
                    r_pend <= 1'b1;
                end
            end
            if (w_wr_a) begin
                r_buf[r_wptr[2:0]] <= w_split_cluster;
            end
            if (w_wr_b) begin
                r_buf[w_ptr_b[2:0]] <= w_close_cluster;
            end
            r_wptr <= w_wptr_nxt;
            if (w_drop) begin
                r_ovf_int <= 1'b1;
            end
            if (r_state == ST_FLUSH) begin
                for (int i = 0; i < MXCLUSTERS; i++) begin
                    r_out[i] <= r_buf[i];
                    r_buf[i] <= BLANK_CLUSTER;
                end
                r_n       <= r_wptr;
                r_ovf     <= r_ovf_int;
                r_ovf_int <= 1'b0;
                r_wptr    <= '0;
                r_pend    <= 1'b0;
                r_valid   <= 1'b1;
            end
        end
    end

    assign cluster0       = r_out[0];
    assign cluster1       = r_out[1];
    assign cluster2       = r_out[2];
    assign cluster3       = r_out[3];
    assign cluster4       = r_out[4];
    assign cluster5       = r_out[5];
    assign cluster6       = r_out[6];
    assign cluster7       = r_out[7];
    assign clusters_valid = r_valid;
    assign n_clusters     = r_n;
    assign overflow       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_gem_cluster_packer.sv
`default_nettype none
// ============================================================================
// Testbench : tb_gem_cluster_packer
// Table vectors, corner sequences and random frames against a run-length model.
// Revision: 1.0
// ============================================================================
module tb_gem_cluster_packer;

    logic        clock;
    logic        reset;
    logic [13:0] cluster0, cluster1, cluster2, cluster3;
    logic [13:0] cluster4, cluster5, cluster6, cluster7;
    logic        clusters_valid;
    logic [3:0]  n_clusters;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    gem_cluster_packer_if bus ();

    gem_cluster_packer dut (
        .clock          (clock),
        .reset          (reset),
        .feb            (bus),
        .cluster0       (cluster0),
        .cluster1       (cluster1),
        .cluster2       (cluster2),
        .cluster3       (cluster3),
        .cluster4       (cluster4),
        .cluster5       (cluster5),
        .cluster6       (cluster6),
        .cluster7       (cluster7),
        .clusters_valid (clusters_valid),
        .n_clusters     (n_clusters),
        .overflow       (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]         nw;
        logic [3:0][4:0]    ids;
        logic [3:0][63:0]   hits;
        logic [7:0][13:0]   ex;
        logic [3:0]         ex_n;
        logic               ex_ovf;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (!bus.feb_ready && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (!bus.feb_ready) chk("ready_timeout", 64'(bus.feb_ready), 64'd1);
    endtask

    task automatic send_word(input logic [4:0] id, input logic [63:0] h);
        wait_ready();
        bus.feb_valid = 1'b1;
        bus.feb_id    = id;
        bus.feb_hits  = h;
        @(negedge clock);
        bus.feb_valid = 1'b0;
    endtask

    // Reference: find maximal runs per FEB, chop into clusters by the cnt rules.
    function automatic void model(input int nw, input logic [3:0][4:0] ids,
                                  input logic [3:0][63:0] hw,
                                  output logic [7:0][13:0] ex, output int n,
                                  output logic ovf);
        logic [13:0] q[$];
        int base, p, s, len, chunk;
        for (int w = 0; w < nw; w++) begin
            if (int'(ids[w]) < 24) begin
                base = int'(ids[w] % 5'd8) * 192 + int'(ids[w] / 5'd8) * 64;
                p = 0;
                while (p < 64) begin
                    if (hw[w][p]) begin
                        s = p;
                        while (p < 64 && hw[w][p]) p++;
                        len = p - s;
`ifdef GEM_CLUSTER_SPLIT_EN
                        for (int off = 0; off < len; off += 8) begin
                            chunk = (len - off > 8) ? 8 : len - off;
                            q.push_back({3'(chunk - 1), 11'(base + s + off)});
                        end
`else
                        chunk = (len > 8) ? 8 : len;
                        q.push_back({3'(chunk - 1), 11'(base + s)});
`endif
                    end else begin
                        p++;
                    end
                end
            end
        end
        n   = (q.size() > 8) ? 8 : q.size();
        ovf = (q.size() > 8);
        for (int i = 0; i < 8; i++) ex[i] = (i < q.size()) ? q[i] : 14'h07FF;
    endfunction

    task automatic do_frame(input string tag, input int nw, input logic [3:0][4:0] ids,
                            input logic [3:0][63:0] hw, input logic [7:0][13:0] ex,
                            input int ex_n, input logic ex_ovf);
        int lat;
        logic [7:0][13:0] got;
        for (int w = 0; w < nw; w++) send_word(ids[w], hw[w]);
        wait_ready();
        bus.frame_end = 1'b1;
        @(negedge clock);
        bus.frame_end = 1'b0;
        lat = 1;
        while (!clusters_valid && lat < 10) begin
            @(negedge clock);
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd2);
        got = {cluster7, cluster6, cluster5, cluster4, cluster3, cluster2, cluster1, cluster0};
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_cluster%0d", tag, i), 64'(got[i]), 64'(ex[i]));
        chk({tag, "_n_clusters"}, 64'(n_clusters), 64'(ex_n));
        chk({tag, "_overflow"}, 64'(overflow), 64'(ex_ovf));
        @(negedge clock);
        chk({tag, "_valid_pulse"}, 64'(clusters_valid), 64'd0);
    endtask

    initial begin
        vec_t v;
        logic [3:0][4:0]  ids;
        logic [3:0][63:0] hw;
        logic [7:0][13:0] ex;
        int               en, k, early_ready, vcnt, nw, mode, s, l;
        logic             eovf;
        logic [63:0]      h;

        // Vector 0: FEB 9, pads 3-5 -> adr 259, cnt 2
        v = '0; v.ex = {8{14'h07FF}};
        v.nw = 1; v.ids[0] = 5'd9; v.hits[0] = 64'h38;
        v.ex[0] = 14'h1103; v.ex_n = 1; vecs[0] = v;
        // Vector 1: FEB 0, pads 0-11
        v = '0; v.ex = {8{14'h07FF}};
        v.nw = 1; v.ids[0] = 5'd0; v.hits[0] = 64'hFFF; v.ex[0] = 14'h3800;
`ifdef GEM_CLUSTER_SPLIT_EN
        v.ex[1] = 14'h1808; v.ex_n = 2;
`else
        v.ex_n = 1;
`endif
        vecs[1] = v;
        // Vector 2: runs never span FEBs
        v = '0; v.ex = {8{14'h07FF}};
        v.nw = 2; v.ids[0] = 5'd0; v.hits[0] = 64'h8000_0000_0000_0000;
        v.ids[1] = 5'd1; v.hits[1] = 64'h1;
        v.ex[0] = 14'h003F; v.ex[1] = 14'h00C0; v.ex_n = 2; vecs[2] = v;
        // Vector 3: FEB 23 (base 1472), 9 isolated pads -> overflow
        v = '0;
        v.nw = 1; v.ids[0] = 5'd23; v.hits[0] = 64'h15555;
        for (int i = 0; i < 8; i++) v.ex[i] = 14'h05C0 + 14'(2 * i);
        v.ex_n = 8; v.ex_ovf = 1'b1; vecs[3] = v;
        // Vector 4: empty frame after overflow
        v = '0; v.ex = {8{14'h07FF}}; vecs[4] = v;
        // Vector 5: FEB 24 discarded, FEB 2 pad 0 -> adr 384
        v = '0; v.ex = {8{14'h07FF}};
        v.nw = 2; v.ids[0] = 5'd24; v.hits[0] = '1;
        v.ids[1] = 5'd2; v.hits[1] = 64'h1;
        v.ex[0] = 14'h0180; v.ex_n = 1; vecs[5] = v;

        reset = 1'b1;
        bus.feb_valid = 1'b0;
        bus.feb_id    = '0;
        bus.feb_hits  = '0;
        bus.frame_end = 1'b0;
        repeat (3) @(negedge clock);
        ex = {cluster7, cluster6, cluster5, cluster4, cluster3, cluster2, cluster1, cluster0};
        for (int i = 0; i < 8; i++) chk($sformatf("reset_cluster%0d", i), 64'(ex[i]), 64'h7FF);
        chk("reset_n_clusters", 64'(n_clusters), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        chk("reset_valid", 64'(clusters_valid), 64'd0);
        chk("reset_ready", 64'(bus.feb_ready), 64'd1);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 6; i++)
            do_frame($sformatf("vec%0d", i), int'(vecs[i].nw), vecs[i].ids, vecs[i].hits,
                     vecs[i].ex, int'(vecs[i].ex_n), vecs[i].ex_ovf);

        // frame_end on cycle 10 of a scan waits for the scan to finish
        wait_ready();
        bus.feb_valid = 1'b1; bus.feb_id = 5'd9; bus.feb_hits = 64'h38;
        @(negedge clock);
        bus.feb_valid = 1'b0;
        k = 1; early_ready = 0;
        while (!clusters_valid && k < 200) begin
            if (bus.feb_ready) early_ready++;
            bus.frame_end = (k == 10);
            @(negedge clock);
            k++;
        end
        bus.frame_end = 1'b0;
        chk("midscan_fe_latency", 64'(k), 64'd66);
        chk("midscan_fe_ready_low", 64'(early_ready), 64'd0);
        chk("midscan_fe_cluster0", 64'(cluster0), 64'h1103);
        chk("midscan_fe_n", 64'(n_clusters), 64'd1);
        @(negedge clock);

        // Reset in the middle of a scan
        send_word(5'd9, 64'h38);
        bus.frame_end = 1'b1;
        @(negedge clock);
        bus.frame_end = 1'b0;
        repeat (18) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("midreset_ready", 64'(bus.feb_ready), 64'd1);
        chk("midreset_cluster0", 64'(cluster0), 64'h7FF);
        chk("midreset_n", 64'(n_clusters), 64'd0);
        chk("midreset_valid", 64'(clusters_valid), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (clusters_valid) vcnt++;
        end
        chk("midreset_no_valid", 64'(vcnt), 64'd0);
        do_frame("after_reset", int'(vecs[0].nw), vecs[0].ids, vecs[0].hits,
                 vecs[0].ex, int'(vecs[0].ex_n), vecs[0].ex_ovf);

        // Random frames against the model
        for (int r = 0; r < 25; r++) begin
            nw = $urandom_range(0, 3);
            ids = '0; hw = '0;
            for (int w = 0; w < nw; w++) begin
                ids[w] = 5'($urandom_range(0, 25));
                mode = $urandom_range(0, 3);
                case (mode)
                    0: h = {$urandom, $urandom} & {$urandom, $urandom};
                    1: h = {$urandom, $urandom} | {$urandom, $urandom};
                    2: h = '1;
                    default: begin
                        s = $urandom_range(0, 63);
                        l = $urandom_range(1, 20);
                        h = '0;
                        for (int j = s; j < s + l && j < 64; j++) h[j] = 1'b1;
                    end
                endcase
                hw[w] = h;
            end
            model(nw, ids, hw, ex, en, eovf);
            do_frame($sformatf("rand%0d", r), nw, ids, hw, ex, en, eovf);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gem_cluster_packer.md
Name: gem_cluster_packer

Overview:
- Transmit-side counterpart of the GEM co-pad finder. Takes per-VFAT 64-pad hit words one FEB at a time and run-length encodes them into 14-bit GEM clusters: adr[10:0] = start pad, cnt[13:11] = additional pads (0-7).
- At frame end it presents up to 8 clusters in the exact format the co-pad finder and its test benches consume.
- Unused slots carry the blank-cluster code.

Parameters:
MXFEB, 24, number of VFAT front-end boards per chamber
MXCLUSTERS, 8, cluster slots per frame
MXPADS, 64, pads per FEB
MXADRB, 11, cluster address width
MXCNTB, 3, cluster count width
MXCLSTB, 14, packed cluster width
BLANK_CLUSTER, 14'h07FF, code for an empty slot (adr bits 10:9 both set, cnt 0)

Ports:
clock  input  1  40 MHz fabric clock
reset  input  1  asynchronous, active-high reset
feb_valid  input  1  hit word offered
feb_ready  output  1  block can accept a hit word this cycle
feb_id  input  5  FEB number, 0-23
feb_hits  input  64  pad hit mask; bit p = pad p
frame_end  input  1  one-cycle strobe: close the current frame
cluster0..cluster7  output  14 each  packed clusters, registered
clusters_valid  output  1  one-cycle pulse when cluster0..7 are updated
n_clusters  output  4  number of non-blank slots, 0-8
overflow  output  1  sticky per frame: at least one cluster was dropped

Behaviour:
- Reset (asynchronous, active-high; clock and reset ports named clock/reset):
  - cluster0..7 = BLANK_CLUSTER; n_clusters = 0; overflow = 0; clusters_valid = 0; feb_ready = 1; FSM = IDLE.
  - Internal buffer is also set to all-blank.
- Address map: col = feb_id/8, row = feb_id%8, base = row*192 + col*64, adr = base + p.
  - feb_id >= 24: the word is accepted and discarded, producing no clusters.
- FSM states and transitions:
  - IDLE: feb_ready = 1. On feb_valid, latch feb_hits, feb_id, base; p = 0; go to SCAN.
  - SCAN: feb_ready = 0. Examine one pad per cycle, so 64 cycles per word.
    - Run tracker holds open, start and len.
    - Hit with no open run: open a run at adr = base + p, len = 0.
    - Hit with an open run: len = len + 1.
    - Miss with an open run: emit the cluster {len[2:0], start}.
    - At p = 63 any open run is emitted in the same cycle. Runs never span FEBs.
    - After p = 63, go to IDLE, or to FLUSH if frame_end is pending.
  - FLUSH (1 cycle):
    - Copy the buffer to cluster0..7 in emission order; set n_clusters; pulse clusters_valid.
    - Clear the buffer to blank, write pointer to 0, overflow to 0 for the new frame. The output overflow flag keeps the closing frame's value.
    - Go to IDLE.
- frame_end timing:
  - In IDLE with no feb_valid: go to FLUSH next cycle. clusters_valid rises 2 cycles after frame_end.
  - Seen during SCAN, or together with feb_valid in IDLE: latched as pending; the FLUSH follows completion of the scan.
  - A second frame_end while one is already pending is ignored.
- Emission:
  - Cluster written at buffer[wptr]; wptr increments.
  - With wptr = 8: the cluster is dropped and the internal overflow flag is set.
  - The overflow output register updates only at FLUSH.
- Run length limit: len is at most 7. Behaviour at len = 7 with a further hit is set by the optional feature.
- Reset mid-scan aborts everything: no clusters_valid, all outputs return to reset values.

Optional Feature:
GEM_CLUSTER_SPLIT_EN
- Defined: a hit arriving with len = 7 emits the current cluster (cnt = 7) and opens a new run at that pad. A 12-pad run therefore yields two clusters.
- Undefined: len saturates at 7 and the excess pads are absorbed. A long run yields a single cnt = 7 cluster at its start pad.

Decomposition:
- Shared package gem_pkg:
  - constants MXFEB, MXCLUSTERS, MXPADS, MXADRB, MXCNTB, MXCLSTB, BLANK_CLUSTER;
  - the feb-to-base address function;
  - the 14-bit cluster field layout, shared with the co-pad finder.
- One sub-module is natural: gem_run_tracker, holding the per-pad run open/extend/emit logic (and the split option). The packer keeps the FSM, buffer and frame control.

Test Plan:
- FEB 9, hits pads 3-5, then frame_end → cluster0 = 14'h1103 (adr 259, cnt 2); cluster1-7 = 14'h07FF; n_clusters = 1; clusters_valid one pulse.
- FEB 0, pads 0-11 → with GEM_CLUSTER_SPLIT_EN: 14'h3800 and 14'h1808, n_clusters = 2. Without it: 14'h3800 only, n_clusters = 1.
- FEB 0 pad 63 and FEB 1 pad 0 in the same frame → adr 63 and adr 192, two separate clusters, each cnt 0.
- FEB 23, alternating hits on 9 pads → first 8 clusters reported, n_clusters = 8, overflow = 1. A following empty frame → all blank, overflow = 0.
- frame_end asserted on cycle 10 of a scan → clusters_valid only after the 64-cycle scan completes; feb_ready stays low throughout.
- reset asserted mid-scan → outputs immediately blank/0 and feb_ready = 1; next frame unaffected.
